// File: rtl/bldc_emulator_pkg.sv
// Shared tables for the BLDC motor emulator: hall code per sector, forward
// drive pair per sector, quadrature Gray sequence and the sector width.
package bldc_emulator_pkg;

    localparam int SECTOR_W = 3;
    localparam logic [2:0] HALL_RESET = 3'b001;

    typedef struct packed {
        logic [2:0] high;
        logic [2:0] low;
    } drive_pair_t;

    function automatic logic [2:0] hall_of(input logic [SECTOR_W-1:0] s);
        case (s)
            3'd0:    return 3'b001;
            3'd1:    return 3'b011;
            3'd2:    return 3'b010;
            3'd3:    return 3'b110;
            3'd4:    return 3'b100;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Forward commutation: phase driven high, phase driven low (bit0=A).
    function automatic drive_pair_t fwd_pair(input logic [SECTOR_W-1:0] s);
        case (s)
            3'd0:    return '{high: 3'b001, low: 3'b010};
            3'd1:    return '{high: 3'b001, low: 3'b100};
            3'd2:    return '{high: 3'b010, low: 3'b100};
            3'd3:    return '{high: 3'b010, low: 3'b001};
            3'd4:    return '{high: 3'b100, low: 3'b001};
            3'd5:    return '{high: 3'b100, low: 3'b010};
            default: return '{high: 3'b000, low: 3'b000};
        endcase
    endfunction

    // Quadrature {B,A} for position index 0..3; forward walks the index up.
    function automatic logic [1:0] gray_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/bldc_quadrature_gen.sv
// Step prescaler and quadrature encoder sequencer. While step_en is high the
// prescaler runs 0..STEP_PERIOD-1; terminal count emits one step in dir.
// restart clears the prescaler without stepping (direction reversal).
// enc_hold freezes the enc output while the internal position keeps moving.
module bldc_quadrature_gen
    import bldc_emulator_pkg::*;
#(
    parameter int STEP_PERIOD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_en,
    input  logic       restart,
    input  logic       dir,
    input  logic       enc_hold,
    output logic [1:0] enc,
    output logic       step
);

    localparam int PW = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    pos;
    logic [1:0]    pos_next;

    assign step     = step_en && !restart && (presc == PW'(STEP_PERIOD - 1));
    assign pos_next = step ? (dir ? pos + 2'd1 : pos - 2'd1) : pos;

    // Prescaler, position index and registered encoder output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            pos   <= 2'd0;
            enc   <= 2'b00;
        end else begin
            if (!step_en || restart || step)
                presc <= '0;
            else
                presc <= presc + 1'b1;
            pos <= pos_next;
            if (!enc_hold)
                enc <= gray_of(pos_next);
        end
    end

endmodule

// File: rtl/bldc_motor_emulator.sv
// BLDC motor emulator: decodes the registered gate drive against the current
// sector, advances an emulated rotor and presents hall and quadrature outputs.
// Optional build macro HALL_FAULT_INJECT_EN adds the hall_disconnect input.
module bldc_motor_emulator
    import bldc_emulator_pkg::*;
#(
    parameter int STEP_PERIOD        = 16,
    parameter int ENC_STEPS_PER_HALL = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          phaseH,
    input  logic [2:0]          phaseL,
`ifdef HALL_FAULT_INJECT_EN
    input  logic                hall_disconnect,
`endif
    output logic [2:0]          hall,
    output logic [1:0]          enc,
    output logic [SECTOR_W-1:0] sector,
    output logic                moving,
    output logic                dir,
    output logic                fault
);

    localparam int SUB_W = (ENC_STEPS_PER_HALL > 1) ? $clog2(ENC_STEPS_PER_HALL) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ENC_STEPS_PER_HALL - 1);

    logic [2:0]          ph_q;
    logic [2:0]          pl_q;
    logic [SUB_W-1:0]    sub;
    logic [SUB_W-1:0]    sub_next;
    logic [SECTOR_W-1:0] sector_next;
    logic                moving_q;
    logic                shoot;
    logic                drv_fwd;
    logic                drv_rev;
    logic                restart;
    logic                step;
    logic                disc;
    drive_pair_t         fp;

`ifdef HALL_FAULT_INJECT_EN
    assign disc = hall_disconnect;
`else
    assign disc = 1'b0;
`endif

    assign fp      = fwd_pair(sector);
    assign shoot   = |(ph_q & pl_q);
    assign drv_fwd = (ph_q == fp.high) && (pl_q == fp.low);
    assign drv_rev = (ph_q == fp.low) && (pl_q == fp.high);
    // Shoot-through and a latched fault both override a valid drive.
    assign moving  = (drv_fwd || drv_rev) && !shoot && !fault;
    // A reversal while already moving restarts the step period.
    assign restart = moving && moving_q && (drv_fwd != dir);

    bldc_quadrature_gen #(
        .STEP_PERIOD (STEP_PERIOD)
    ) u_quad (
        .clk      (clk),
        .reset_n  (reset_n),
        .step_en  (moving),
        .restart  (restart),
        .dir      (drv_fwd),
        .enc_hold (disc),
        .enc      (enc),
        .step     (step)
    );

    // Sub-position and sector advance on each encoder step.
    always_comb begin
        sub_next    = sub;
        sector_next = sector;
        if (step) begin
            if (drv_fwd) begin
                if (sub == SUB_LAST) begin
                    sub_next    = '0;
                    sector_next = (sector == SECTOR_W'(5)) ? '0 : sector + 1'b1;
                end else begin
                    sub_next = sub + 1'b1;
                end
            end else begin
                if (sub == '0) begin
                    sub_next    = SUB_LAST;
                    sector_next = (sector == '0) ? SECTOR_W'(5) : sector - 1'b1;
                end else begin
                    sub_next = sub - 1'b1;
                end
            end
        end
    end

    // Input stage, rotor position, direction, fault latch and hall output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q     <= 3'b000;
            pl_q     <= 3'b000;
            sector   <= '0;
            sub      <= '0;
            dir      <= 1'b1;
            fault    <= 1'b0;
            moving_q <= 1'b0;
            hall     <= HALL_RESET;
        end else begin
            ph_q     <= phaseH;
            pl_q     <= phaseL;
            fault    <= fault | shoot;
            moving_q <= moving;
            if (moving)
                dir <= drv_fwd;
            sector   <= sector_next;
            sub      <= sub_next;
            hall     <= disc ? 3'b000 : hall_of(sector_next);
        end
    end

endmodule

// File: doc/bldc_motor_emulator.md
BLDC_MOTOR_EMULATOR -- requirements
Module: bldc_motor_emulator

Interface
REQ-001 SHALL have parameter STEP_PERIOD, default 16: clock cycles per quadrature encoder step while moving (minimum 2).
REQ-002 SHALL have parameter ENC_STEPS_PER_HALL, default 4: encoder steps per hall sector (minimum 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port phaseH  input  3  high-side gate drive; bit0=A, bit1=B, bit2=C.
REQ-006 SHALL have port phaseL  input  3  low-side gate drive; same bit order.
REQ-007 SHALL have port hall  output  3  emulated hall sensor code, registered.
REQ-008 SHALL have port enc  output  2  emulated quadrature encoder {B,A}, registered.
REQ-009 SHALL have port sector  output  3  current electrical sector, 0..5.
REQ-010 SHALL have port moving  output  1  high while a valid commutation drive is being applied.
REQ-011 SHALL have port dir  output  1  1 = forward, 0 = reverse; last valid direction.
REQ-012 SHALL have port fault  output  1  sticky shoot-through flag.

Function
REQ-013 SHALL register phaseH/phaseL in one input stage; all decoding uses the registered copy.
REQ-014 SHALL map sector to hall as 0:001, 1:011, 2:010, 3:110, 4:100, 5:101.
REQ-015 SHALL treat the forward drive (high phase, low phase) per sector as 0:(A,B), 1:(A,C), 2:(B,C), 3:(B,A), 4:(C,A), 5:(C,B).
REQ-016 SHALL treat the reverse drive for a sector as its forward pair with high and low swapped.
REQ-017 SHALL hold the position when the drive is any other pattern, including all-off and multiple highs: moving=0, prescaler cleared, dir retained.
REQ-018 SHALL run a prescaler 0..STEP_PERIOD-1 while moving; on terminal count, emit one encoder step in direction dir and clear the prescaler.
REQ-019 SHALL make the first enc change exactly STEP_PERIOD+1 cycles after a valid drive is first presented; later changes follow every STEP_PERIOD cycles.
REQ-020 SHALL clear the prescaler when the drive changes between forward and reverse, or from hold to moving; sub-position is kept.
REQ-021 SHALL sequence enc forward as 00->01->11->10->00 and reverse as the opposite order, one transition per step.
REQ-022 SHALL step a sub-position counter 0..ENC_STEPS_PER_HALL-1 with each forward step; wrapping to 0 advances sector (5->0 wraps).
REQ-023 SHALL decrement the sub-position counter on each reverse step; wrapping from 0 to N-1 decrements sector (0->5 wraps).
REQ-024 SHALL update hall and sector in the same cycle as the enc transition that causes the sector change.
REQ-025 SHALL set fault one cycle after any registered phaseH[i]&phaseL[i]; fault stays set until reset.
REQ-026 SHALL, while fault=1, force moving=0 and hold hall, enc, sector and sub-position.
REQ-027 SHALL let shoot-through take priority over a valid drive in the same sample.

Reset
REQ-028 SHALL asynchronously set hall=001, enc=00, sector=0, sub-position=0, prescaler=0, moving=0, dir=1, fault=0 and the input stage to 0 when reset_n is low.
REQ-029 SHALL abandon any partial step on reset mid-operation; the first edge after release samples inputs only.

Configuration
REQ-030 SHALL, with HALL_FAULT_INJECT_EN defined, add input hall_disconnect (1 bit): while high, hall reads 000, enc holds, position tracking continues internally, and hall reflects the true sector the cycle after release.
REQ-031 SHALL, without HALL_FAULT_INJECT_EN, omit the hall_disconnect port and always drive hall from sector.

Structure
REQ-032 SHALL place the sector-to-hall table, the forward drive-pair table, the quadrature Gray sequence and the sector width constant in shared package bldc_emulator_pkg.
REQ-033 SHALL implement the prescaler plus quadrature sequencing as sub-module bldc_quadrature_gen (inputs step enable and dir; outputs enc and a step strobe).

Verification
REQ-034 SHALL cover: reset release, hold phaseH=001/phaseL=010 -> enc=01 at cycle 17, 11 at cycle 33; hall=011 after 4 steps (cycle 65).
REQ-035 SHALL cover: continuous forward drive tracking the sector -> hall walks 001,011,010,110,100,101,001; sector wraps 5->0.
REQ-036 SHALL cover: reset, then reverse drive phaseH=010/phaseL=001 -> enc 00->10, sector 0->5 after 4 steps, hall=101.
REQ-037 SHALL cover: phaseH=001, phaseL=001 mid-step -> fault=1 next cycle, enc/hall frozen, valid drive afterwards ignored until reset_n pulse.
REQ-038 SHALL cover: drive switched to all-off at prescaler 10, then restored -> no enc change while off; next enc change 17 cycles after restore.
REQ-039 SHALL cover: with HALL_FAULT_INJECT_EN defined, hall_disconnect=1 for 200 cycles of forward drive -> hall=000 throughout, then the correct sector code the cycle after release.
